// File: rtl/wb_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wb_burst_arbiter
//
// Two-master Wishbone arbiter between the data cache (master 0) and the
// instruction cache (master 1) and the single core bus master port.
//
// A grant is taken in S_IDLE and registered. It is then held for the whole
// Wishbone cycle (cyc high to cyc low), so 4-beat line bursts are never split.
// Both masters requesting together are served round robin. A per-beat
// watchdog answers a hung slave with a one-cycle synthetic error, so a cache
// can never stall forever.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   m0_* / m1_*            master 0 (dcache) / master 1 (icache) slave ports:
//     mN_cyc, mN_stb, mN_we, mN_4_burst   controls in
//     mN_adr, mN_o_dat, mN_sel            address, write data, byte select in
//     mN_i_dat, mN_ack, mN_err            read data and responses out
//   o_wb_*                 bus master outputs (cyc/stb/we/4_burst/adr/dat/sel)
//   i_wb_dat, i_wb_ack, i_wb_err   bus responses in
//   o_gnt                  one-hot current grant (debug), 0 while idle
// -----------------------------------------------------------------------------
module wb_burst_arbiter #(
  parameter int WB_ADDR_W   = 24,
  parameter int RW          = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8    // TIMEOUT_CYC must be < 2**TO_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // master 0 (dcache)
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic                 m0_4_burst,
  input  logic [WB_ADDR_W-1:0] m0_adr,
  input  logic [RW-1:0]        m0_o_dat,
  input  logic [1:0]           m0_sel,
  output logic [RW-1:0]        m0_i_dat,
  output logic                 m0_ack,
  output logic                 m0_err,
  // master 1 (icache)
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic                 m1_4_burst,
  input  logic [WB_ADDR_W-1:0] m1_adr,
  input  logic [RW-1:0]        m1_o_dat,
  input  logic [1:0]           m1_sel,
  output logic [RW-1:0]        m1_i_dat,
  output logic                 m1_ack,
  output logic                 m1_err,
  // core bus
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic                 o_wb_4_burst,
  output logic [WB_ADDR_W-1:0] o_wb_adr,
  output logic [RW-1:0]        o_wb_dat,
  output logic [1:0]           o_wb_sel,
  input  logic [RW-1:0]        i_wb_dat,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err,
  // debug
  output logic [1:0]           o_gnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] WDOG_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic            gnt, gnt_nxt;            // 0 = master 0, 1 = master 1
  logic            last_gnt, last_gnt_nxt;  // master served by the last cycle
  logic [TO_W-1:0] wdog, wdog_nxt;
  logic [1:0]      beat_cnt, beat_cnt_nxt;  // beat position inside a line burst

  logic            sel_cyc;
  logic            real_ack;
  logic            real_err;
  logic            timeout;
  logic            beat_done;

  // State and bookkeeping registers; reset drops the bus immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;   // so master 0 wins the first contended arbitration
      wdog     <= {TO_W{1'b0}};
      beat_cnt <= 2'b00;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      wdog     <= wdog_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Route the granted master onto the bus and fan bus read data back out.
  always_comb begin
    sel_cyc      = 1'b0;
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_4_burst = 1'b0;
    o_wb_adr     = {WB_ADDR_W{1'b0}};
    o_wb_dat     = {RW{1'b0}};
    o_wb_sel     = 2'b00;
    m0_i_dat     = {RW{1'b0}};
    m1_i_dat     = {RW{1'b0}};
    if (state == S_BUSY) begin
      if (gnt) begin
        sel_cyc      = m1_cyc;
        o_wb_stb     = m1_cyc & m1_stb;   // never strobe outside a cycle
        o_wb_we      = m1_we;
        o_wb_4_burst = m1_4_burst;
        o_wb_adr     = m1_adr;
        o_wb_dat     = m1_o_dat;
        o_wb_sel     = m1_sel;
      end else begin
        sel_cyc      = m0_cyc;
        o_wb_stb     = m0_cyc & m0_stb;
        o_wb_we      = m0_we;
        o_wb_4_burst = m0_4_burst;
        o_wb_adr     = m0_adr;
        o_wb_dat     = m0_o_dat;
        o_wb_sel     = m0_sel;
      end
      o_wb_cyc = sel_cyc;
      m0_i_dat = i_wb_dat;
      m1_i_dat = i_wb_dat;
    end else begin
      sel_cyc = 1'b0;
    end
  end

  // Qualify slave responses, raise the synthetic error and steer to the owner.
  always_comb begin
    // A response outside an active cycle belongs to nobody and is dropped.
    real_ack  = o_wb_cyc & i_wb_ack;
    real_err  = o_wb_cyc & i_wb_err;
    // A real response in the same cycle as the limit always wins.
    timeout   = o_wb_stb & ~(real_ack | real_err) & (wdog == TO_LIM);
    beat_done = o_wb_stb & (real_ack | real_err | timeout);
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    o_gnt     = 2'b00;
    if (state == S_BUSY) begin
      if (gnt) begin
        m1_ack = real_ack;
        m1_err = real_err | timeout;
        o_gnt  = 2'b10;
      end else begin
        m0_ack = real_ack;
        m0_err = real_err | timeout;
        o_gnt  = 2'b01;
      end
    end else begin
      o_gnt = 2'b00;
    end
  end

  // Arbitration, grant hold/release, watchdog and burst beat counting.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    wdog_nxt     = wdog;
    beat_cnt_nxt = beat_cnt;
    case (state)
      S_IDLE: begin
        wdog_nxt = {TO_W{1'b0}};
        if (m0_cyc | m1_cyc) begin
          state_nxt    = S_BUSY;
          beat_cnt_nxt = 2'b00;
          if (m0_cyc & m1_cyc) begin
            gnt_nxt = ~last_gnt;
          end else begin
            gnt_nxt = m1_cyc;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!sel_cyc) begin
          // Owner closed its cycle: one idle bus cycle before the next grant.
          state_nxt    = S_IDLE;
          last_gnt_nxt = gnt;
          wdog_nxt     = {TO_W{1'b0}};
        end else begin
          state_nxt = S_BUSY;
          if (!o_wb_stb || beat_done) begin
            wdog_nxt = {TO_W{1'b0}};
          end else begin
            wdog_nxt = wdog + WDOG_ONE;
          end
          if (beat_done && o_wb_4_burst) begin
            beat_cnt_nxt = beat_cnt + 2'b01;   // wraps 3 -> 0
          end else begin
            beat_cnt_nxt = beat_cnt;
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        gnt_nxt      = 1'b0;
        last_gnt_nxt = 1'b1;
        wdog_nxt     = {TO_W{1'b0}};
        beat_cnt_nxt = 2'b00;
      end
    endcase
  end

endmodule
